// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
//   op_e    : operation code carried on the op bus (MULTU, MULT, DIVU, DIV)
//   state_e : sequencer state
//   CNT_W   : iteration counter width for the default 32-bit build
package mult_div_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'd0,
      OP_MULT  = 2'd1,
      OP_DIVU  = 2'd2,
      OP_DIV   = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   // Counter must hold WIDTH-1.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int MD_WIDTH = 32;
   localparam int CNT_W    = cnt_width(MD_WIDTH);

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
//   master (pipeline): drives start, op, operandA, operandB, abort
//   slave  (unit)    : drives busy, done, hi, lo, divByZero
interface mult_div_unit_if #(parameter int WIDTH = 32);

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operandA;
   logic [WIDTH-1:0] operandB;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             divByZero;

   modport master (
      output start, op, operandA, operandB, abort,
      input  busy, done, hi, lo, divByZero
   );

   modport slave (
      input  start, op, operandA, operandB, abort,
      output busy, done, hi, lo, divByZero
   );

endinterface

// File: rtl/add_sub_nbits.sv
// Shared adder/subtractor.
//   sub   : 0 -> sum = a + b, 1 -> sum = a - b
//   a, b  : WIDTH-bit operands
//   sum   : WIDTH-bit result
//   carry : carry out; when subtracting, 1 means a >= b (no borrow)
module add_sub_nbits #(
   parameter int WIDTH = 33
) (
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH-1:0] b_eff;

   assign b_eff        = sub ? ~b : b;
   assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with internal HI/LO registers.
// One bit per cycle through a single WIDTH+1 adder/subtractor; every
// operation takes WIDTH+2 cycles from start to done.
//   clock, resetN : rising-edge clock, asynchronous active-low reset
//   bus (slave)   : start/op/operandA/operandB/abort in,
//                   busy/done/hi/lo/divByZero out (all registered)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting; start latches op and operands
// ST_PREP | take operand magnitudes, record result signs, load counter
// ST_RUN  | one multiply/divide bit per cycle until counter hits 0
// ST_FIX  | apply signs (or divide-by-zero result), load HI/LO, done
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic            clock,
   input  logic            resetN,
   mult_div_unit_if.slave  bus
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

   logic             is_div, is_signed, a_neg, b_neg;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   as_a, as_b, as_sum;
   logic             as_carry;
   logic [2*WIDTH-1:0] prod_mag, prod_res;

   assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
   assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign a_neg     = is_signed & a_q[WIDTH-1];
   assign b_neg     = is_signed & b_q[WIDTH-1];
   assign abs_a     = a_neg ? -a_q : a_q;
   assign abs_b     = b_neg ? -b_q : b_q;

   // Multiply adds the multiplicand into the high half; divide subtracts
   // the divisor from the partial remainder with the next dividend bit
   // shifted in.
   assign as_a = is_div ? {acc_hi_q, acc_lo_q[WIDTH-1]} : {1'b0, acc_hi_q};
   assign as_b = {1'b0, opnd_q};

   add_sub_nbits #(.WIDTH(WIDTH + 1)) u_add_sub (
      .sub   (is_div),
      .a     (as_a),
      .b     (as_b),
      .sum   (as_sum),
      .carry (as_carry)
   );

   assign prod_mag = {acc_hi_q, acc_lo_q};
   assign prod_res = neg_q ? -prod_mag : prod_mag;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MULTU;
         a_q       <= '0;
         b_q       <= '0;
         opnd_q    <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         opnd_q    <= opnd_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_PREP;
         ST_PREP: state_d = ST_RUN;
         ST_RUN:  if (cnt_q == '0) state_d = ST_FIX;
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Abort cancels in flight and also drops a same-cycle start.
      if (bus.abort) state_d = ST_IDLE;
   end

   always_comb begin
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      opnd_d    = opnd_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      done_d    = 1'b0;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               op_d = op_e'(bus.op);
               a_d  = bus.operandA;
               b_d  = bus.operandB;
            end
         end
         ST_PREP: begin
            acc_hi_d  = '0;
            cnt_d     = CNT_LOAD;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            opnd_d    = is_div ? abs_b : abs_a;
            acc_lo_d  = is_div ? abs_a : abs_b;
         end
         ST_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (is_div) begin
               acc_hi_d = as_carry ? as_sum[WIDTH-1:0] : as_a[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], as_carry};
            end else if (acc_lo_q[0]) begin
               {acc_hi_d, acc_lo_d} = {as_sum, acc_lo_q[WIDTH-1:1]};
            end else begin
               {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
            end
         end
         ST_FIX: begin
            done_d = 1'b1;
            dbz_d  = 1'b0;
            if (is_div && (b_q == '0)) begin
               lo_d  = '1;
               hi_d  = a_q;
               dbz_d = 1'b1;
            end else if (is_div) begin
               lo_d = neg_q     ? -acc_lo_q : acc_lo_q;
               hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
            end else begin
               {hi_d, lo_d} = prod_res;
            end
         end
         default: ;
      endcase
      if (bus.abort) begin
         done_d = 1'b0;
         dbz_d  = dbz_q;
         hi_d   = hi_q;
         lo_d   = lo_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.divByZero = dbz_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit for the MIPS pipeline's HI/LO path. It executes MULT, MULTU, DIV and DIVU in a fixed WIDTH+2 busy cycles using one shared add/subtract datapath, and holds the results in internal HI/LO registers. It sits beside the EX-stage ALU: the pipeline issues `start`, stalls on `busy`, and reads `hi`/`lo` for MFHI/MFLO. `abort` is driven on a pipeline flush.

## Interface
- WIDTH, 32, operand and result width; even, ≥4.
- clock  in  1  single clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- start  in  1  launch operation; sampled only when `busy`=0.
- op  in  2  0=MULTU, 1=MULT, 2=DIVU, 3=DIV; sampled with `start`.
- operandA  in  WIDTH  multiplicand or dividend (rs).
- operandB  in  WIDTH  multiplier or divisor (rt).
- abort  in  1  synchronous cancel of an operation in flight.
- busy  out  1  operation in progress; pipeline stalls on it.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi  out  WIDTH  HI register: product high half or remainder.
- lo  out  WIDTH  LO register: product low half or quotient.
- divByZero  out  1  last completed DIV/DIVU had divisor 0; held until next done.

## Operation
- FSM states: IDLE, PREP, RUN, FIX.
  - IDLE: on `start`, latch op and operands, go to PREP.
  - PREP (1 cycle): for signed ops, take the magnitudes of the operands and record the result signs; clear the accumulator; load the iteration counter with WIDTH−1.
  - RUN (WIDTH cycles): process one bit per cycle.
    - Multiply: shift-add into a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract.
    - The counter decrements each cycle; leave RUN when it reaches 0.
  - FIX (1 cycle): apply signs, load hi/lo, pulse done, return to IDLE.
- Multiply result: {hi,lo} = full 2·WIDTH product, two's complement for MULT.
- Divide result: lo = quotient, hi = remainder.
  - DIV truncates toward zero.
  - The remainder takes the sign of the dividend.
- Divide by zero: lo = all ones, hi = operandA, divByZero=1. Same result for signed and unsigned.
- Signed overflow: DIV of −2^(WIDTH−1) by −1 gives lo=−2^(WIDTH−1), hi=0, divByZero=0.
- `busy`=1 in PREP, RUN and FIX; `busy`=0 in IDLE.
- `start` while busy is ignored; no queueing.
- `abort`, when state ≠ IDLE:
  - Next edge returns to IDLE.
  - No done pulse; hi, lo and divByZero are unchanged.
- `abort` and `start` together in IDLE: abort wins, start is dropped.
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, hi=0, lo=0, divByZero=0.

## Timing
- Let E0 be the rising edge that samples start=1 with busy=0.
- busy rises after E0 and stays high through edge E(WIDTH+2).
- At E(WIDTH+2), hi/lo/divByZero load and done goes high for one cycle with busy=0.
- Latency from start to done is WIDTH+2 cycles (34 for WIDTH=32).
- A start sampled in the cycle where done is high is accepted; back-to-back issue interval is WIDTH+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `mult_div_pkg` holds:
  - typedef enum for op (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - typedef enum for FSM state;
  - localparam for the counter width, $clog2(WIDTH).
- Sub-module `add_sub_nbits` (parameter WIDTH+1, ports: sub, a, b, sum, carry) is the shared adder/subtractor. Multiply uses it as an adder; divide uses it as a subtractor, with the carry deciding the restore.
- Top module contains the FSM, counter, sign handling and HI/LO registers.

## Test plan
All scenarios use WIDTH=32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after E0; busy high for cycles 1..33.
- MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 7 → lo=14, hi=2.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=0x00000064, divByZero=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, divByZero=0.
- Start a MULT; raise abort at cycle 10 → busy low next cycle, no done, hi/lo keep the prior result.
- Start pulses during busy are ignored.
- resetN low mid-RUN → all outputs 0 immediately.
- Back-to-back: issue a second start in the done cycle → second done 34 cycles later.
